// File: rtl/red_seq.sv
// Byte-lane reduction sequencer: accumulates the four sign-extended byte lanes
// of two latched 16-bit operands through the shared ALU adder over four cycles.
module red_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        chain,
   input  logic [15:0] rs,
   input  logic [15:0] rt,
   output logic        busy,
   output logic        done,
   output logic [15:0] result,
   output logic [15:0] add_a,
   output logic [15:0] add_b,
   output logic        add_padd,
   output logic        add_sub,
   output logic        add_red,
   input  logic [15:0] add_sum
);

   localparam int unsigned DW = 16;
   localparam int unsigned LW = 8;

   typedef enum logic [2:0] {IDLE, S0, S1, S2, S3, DONE} state_t;

   state_t        state;
   logic [DW-1:0] acc;
   logic [DW-1:0] op_rs;
   logic [DW-1:0] op_rt;

   function automatic logic [DW-1:0] sext(input logic [LW-1:0] b);
      return {{(DW-LW){b[LW-1]}}, b};
   endfunction

   // Wrapping adds only; packed/subtract modes are never requested.
   assign add_padd = 1'b0;
   assign add_sub  = 1'b0;

   // Adder operands are registered one step ahead so they are valid for the whole state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         acc     <= '0;
         op_rs   <= '0;
         op_rt   <= '0;
         result  <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         add_a   <= '0;
         add_b   <= '0;
         add_red <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  op_rs   <= rs;
                  op_rt   <= rt;
                  acc     <= chain ? result : '0;
                  add_a   <= chain ? result : '0;
                  add_b   <= sext(rs[LW-1:0]);
                  add_red <= 1'b1;
                  busy    <= 1'b1;
                  state   <= S0;
               end else begin
                  add_a   <= '0;
                  add_b   <= '0;
                  add_red <= 1'b0;
                  busy    <= 1'b0;
                  state   <= IDLE;
               end
            end
            S0: begin
               acc   <= add_sum;
               add_a <= add_sum;
               add_b <= sext(op_rs[DW-1:LW]);
               state <= S1;
            end
            S1: begin
               acc   <= add_sum;
               add_a <= add_sum;
               add_b <= sext(op_rt[LW-1:0]);
               state <= S2;
            end
            S2: begin
               acc   <= add_sum;
               add_a <= add_sum;
               add_b <= sext(op_rt[DW-1:LW]);
               state <= S3;
            end
            S3: begin
               acc     <= add_sum;
               result  <= add_sum;
               add_a   <= '0;
               add_b   <= '0;
               add_red <= 1'b0;
               busy    <= 1'b0;
               done    <= 1'b1;
               state   <= DONE;
            end
            default: begin
               add_a   <= '0;
               add_b   <= '0;
               add_red <= 1'b0;
               busy    <= 1'b0;
               done    <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_red_seq.sv
// Scoreboard bench for red_seq with a behavioural adder closing the add_* loop.
module tb_red_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        chain;
   logic [15:0] rs;
   logic [15:0] rt;
   logic        busy;
   logic        done;
   logic [15:0] result;
   logic [15:0] add_a;
   logic [15:0] add_b;
   logic        add_padd;
   logic        add_sub;
   logic        add_red;
   logic [15:0] add_sum;

   int          checks   = 0;
   int          errors   = 0;
   int          done_cnt = 0;
   logic [15:0] exp_q[$];
   logic [15:0] model_res = 16'h0000;

   red_seq dut (
      .clk(clk), .rst(rst), .start(start), .chain(chain), .rs(rs), .rt(rt),
      .busy(busy), .done(done), .result(result), .add_a(add_a), .add_b(add_b),
      .add_padd(add_padd), .add_sub(add_sub), .add_red(add_red), .add_sum(add_sum)
   );

   always #5 clk = ~clk;

   assign add_sum = add_a + add_b;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] sx(input logic [7:0] b);
      return {{8{b[7]}}, b};
   endfunction

   function automatic logic [15:0] ref_red(input logic [15:0] a, input logic [15:0] x,
                                           input logic [15:0] y);
      return a + sx(x[7:0]) + sx(x[15:8]) + sx(y[7:0]) + sx(y[15:8]);
   endfunction

   // Scoreboard: every done pulse consumes one expected result.
   always @(negedge clk) begin
      if (!rst && done) begin
         done_cnt++;
         if (exp_q.size() == 0) check("spurious_done", 32'd1, 32'd0);
         else check("result", result, exp_q.pop_front());
      end
   end

   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic ch,
                         input logic mut, input logic poke);
      logic [15:0] init;
      int          d0;
      @(negedge clk);
      start = 1'b1; rs = a; rt = b; chain = ch;
      init      = ch ? model_res : 16'h0000;
      model_res = ref_red(init, a, b);
      exp_q.push_back(model_res);
      d0 = done_cnt;
      @(posedge clk);
      #1 start = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         if (k == 1) begin
            check("s0_add_a", add_a, init);
            check("s0_add_b", add_b, sx(a[7:0]));
         end
         if (k <= 4) begin
            check("busy", busy, 1);
            check("add_red", add_red, 1);
            check("early_done", done, 0);
         end
         if (k == 2) begin
            if (mut) rs = 16'h1234;
            if (poke) start = 1'b1;
         end
         if (k == 3) start = 1'b0;
         if (k == 5) begin
            check("done_at_5", done, 1);
            check("busy_in_done", busy, 0);
            check("red_in_done", add_red, 0);
         end
      end
      @(posedge clk);
      #1 check("done_count", done_cnt - d0, 1);
      if (poke) begin
         repeat (6) @(negedge clk);
         check("ignored_start", done_cnt - d0, 1);
      end
   endtask

   initial begin
      int d0;
      rst = 1'b1; start = 1'b0; chain = 1'b0; rs = '0; rt = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_result", result, 16'h0000);
      check("rst_add_a", add_a, 16'h0000);
      check("rst_add_b", add_b, 16'h0000);
      check("rst_add_red", add_red, 0);
      check("tie_padd_sub", {add_padd, add_sub}, 2'b00);
      rst = 1'b0;

      run_op(16'h0102, 16'h0304, 1'b0, 1'b0, 1'b0);
      check("basic_sum", result, 16'h000A);
      run_op(16'h8080, 16'h8080, 1'b0, 1'b0, 1'b0);
      check("sext_neg", result, 16'hFE00);
      run_op(16'h7F7F, 16'h7F7F, 1'b0, 1'b0, 1'b0);
      check("sext_pos", result, 16'h01FC);
      run_op(16'hFF01, 16'h0000, 1'b0, 1'b1, 1'b0);
      check("mixed_stable", result, 16'h0000);
      run_op(16'h0505, 16'h0505, 1'b0, 1'b0, 1'b0);

      // Asynchronous reset in the middle of S2 aborts without a done pulse.
      @(negedge clk);
      start = 1'b1; rs = 16'h1111; rt = 16'h2222; chain = 1'b0;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_result", result, 16'h0000);
      model_res = 16'h0000;
      d0 = done_cnt;
      @(negedge clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      check("abort_no_done", done_cnt - d0, 0);

      run_op(16'h0102, 16'h0304, 1'b1, 1'b0, 1'b0);
      check("chain_after_rst", result, 16'h000A);

      // Build up 0x7F00, nudge to 0x7F90, then cross the signed boundary.
      run_op(16'h7F7F, 16'h7F7F, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 63; i++) run_op(16'h7F7F, 16'h7F7F, 1'b1, 1'b0, 1'b0);
      check("preload", result, 16'h7F00);
      run_op(16'h4848, 16'h0000, 1'b1, 1'b0, 1'b0);
      check("preload_7f90", result, 16'h7F90);
      run_op(16'h7F7F, 16'h7F7F, 1'b1, 1'b0, 1'b0);
      check("chain_wrap", result, 16'h818C);

      // start held high: one done every 5 cycles.
      @(negedge clk);
      start = 1'b1; chain = 1'b0; rs = 16'h0102; rt = 16'h0304;
      for (int i = 0; i < 3; i++) exp_q.push_back(ref_red(16'h0000, 16'h0102, 16'h0304));
      model_res = ref_red(16'h0000, 16'h0102, 16'h0304);
      d0 = done_cnt;
      @(posedge clk);
      for (int c = 1; c <= 15; c++) begin
         @(negedge clk);
         #1;
         check("b2b_done", done, (c % 5) == 0);
         if (c == 14) start = 1'b0;
      end
      @(posedge clk);
      #1 check("b2b_count", done_cnt - d0, 3);

      run_op(16'h0203, 16'h0401, 1'b1, 1'b0, 1'b1);

      repeat (3) @(negedge clk);
      check("queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
